// File: rtl/conv_wave_sequencer.sv
// Row-wave sequencer for the conv engine: validates the layer shape, steps kernel rows
// into the systolic array, pops input-buffer columns and requests row refills.
module conv_wave_sequencer #(
    parameter int BANK_WIDTH = 64,
    parameter int ROW_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_async_n_i,
    input  logic                  start_i,
    input  logic [31:0]           cfg_img_w_i,
    input  logic [31:0]           cfg_img_h_i,
    input  logic [3:0]            cfg_kernel_r_i,
    output logic                  ib_start_o,
    input  logic                  ib_ready_i,
    output logic [BANK_WIDTH-1:0] pop_o,
    output logic                  pre_wave_done_o,
    input  logic                  sa_ready_i,
    output logic                  wave_valid_o,
    output logic [3:0]            kr_idx_o,
    output logic [ROW_W-1:0]      row_idx_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_cfg_o
);

    // state       | meaning
    // IDLE        | waiting for start_i, indices hold last layer's values
    // CHECK       | shape validation, err or prefetch kick
    // PREFETCH    | waiting for the first full window
    // WAVE        | stepping kernel rows into the array
    // RETIRE      | row consumed, request refill if rows remain
    // GUARD       | one dead cycle so a stale ib_ready is not trusted
    // WAIT_REFILL | waiting for the refilled row
    // DONE        | layer complete pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_PREFETCH,
        S_WAVE,
        S_RETIRE,
        S_GUARD,
        S_WAIT_REFILL,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     img_w_q, img_w_d;
    logic [31:0]     img_h_q, img_h_d;
    logic [3:0]      kernel_q, kernel_d;
    logic [3:0]      kr_idx_q, kr_idx_d;
    logic [ROW_W-1:0] row_idx_q, row_idx_d;
    logic [31:0]     fetched_q, fetched_d;

    logic [31:0]           k_ext;
    logic                  cfg_illegal;
    logic                  last_kr;
    logic [ROW_W-1:0]      row_inc;
    logic [31:0]           rows_total;
    logic                  last_row;
    logic                  refill_needed;
    logic [BANK_WIDTH-1:0] col_mask;
    logic                  advance_row;

    logic                  ib_start;
    logic [BANK_WIDTH-1:0] pop;
    logic                  pre_wave_done;
    logic                  wave_valid;
    logic                  done;
    logic                  err_cfg;

    always_comb begin
        k_ext         = {28'd0, kernel_q};
        cfg_illegal   = (kernel_q == 4'd0) || (img_w_q == 32'd0) ||
                        (img_w_q > 32'(BANK_WIDTH)) || (k_ext > img_w_q) ||
                        (img_h_q < (k_ext + 32'd1));
        last_kr       = (kr_idx_q == (kernel_q - 4'd1));
        row_inc       = row_idx_q + ROW_W'(1);
        rows_total    = img_h_q - k_ext + 32'd1;
        last_row      = (32'(row_inc) == rows_total);
        refill_needed = (fetched_q < img_h_q);
        for (int i = 0; i < BANK_WIDTH; i++) begin
            col_mask[i] = (32'(i) < img_w_q);
        end
    end

    always_comb begin
        state_d       = state_q;
        img_w_d       = img_w_q;
        img_h_d       = img_h_q;
        kernel_d      = kernel_q;
        kr_idx_d      = kr_idx_q;
        row_idx_d     = row_idx_q;
        fetched_d     = fetched_q;
        advance_row   = 1'b0;
        ib_start      = 1'b0;
        pop           = '0;
        pre_wave_done = 1'b0;
        wave_valid    = 1'b0;
        done          = 1'b0;
        err_cfg       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    img_w_d  = cfg_img_w_i;
                    img_h_d  = cfg_img_h_i;
                    kernel_d = cfg_kernel_r_i;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (cfg_illegal) begin
                    err_cfg = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    ib_start = 1'b1;
                    state_d  = S_PREFETCH;
                end
            end
            S_PREFETCH: begin
                if (ib_ready_i) begin
                    row_idx_d = '0;
                    kr_idx_d  = 4'd0;
                    fetched_d = k_ext + 32'd1;
                    state_d   = S_WAVE;
                end
            end
            S_WAVE: begin
                wave_valid = 1'b1;
                if (sa_ready_i) begin
                    if (last_kr) begin
                        pop     = col_mask;
                        state_d = S_RETIRE;
                    end else begin
                        kr_idx_d = kr_idx_q + 4'd1;
                    end
                end
            end
            S_RETIRE: begin
                if (refill_needed) begin
                    pre_wave_done = 1'b1;
                    fetched_d     = fetched_q + 32'd1;
                    state_d       = S_GUARD;
                end else begin
                    advance_row = 1'b1;
                end
            end
            S_GUARD: begin
                state_d = S_WAIT_REFILL;
            end
            S_WAIT_REFILL: begin
                if (ib_ready_i) begin
                    advance_row = 1'b1;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Shared exit from RETIRE (no refill) and WAIT_REFILL
        if (advance_row) begin
            row_idx_d = row_inc;
            if (last_row) begin
                state_d = S_DONE;
            end else begin
                kr_idx_d = 4'd0;
                state_d  = S_WAVE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_async_n_i) begin
        if (!rst_async_n_i) begin
            state_q   <= S_IDLE;
            img_w_q   <= '0;
            img_h_q   <= '0;
            kernel_q  <= '0;
            kr_idx_q  <= '0;
            row_idx_q <= '0;
            fetched_q <= '0;
        end else begin
            state_q   <= state_d;
            img_w_q   <= img_w_d;
            img_h_q   <= img_h_d;
            kernel_q  <= kernel_d;
            kr_idx_q  <= kr_idx_d;
            row_idx_q <= row_idx_d;
            fetched_q <= fetched_d;
        end
    end

    // All strobes decode from state_q, so the async reset clears them immediately
    assign ib_start_o      = ib_start;
    assign pop_o           = pop;
    assign pre_wave_done_o = pre_wave_done;
    assign wave_valid_o    = wave_valid;
    assign done_o          = done;
    assign err_cfg_o       = err_cfg;
    assign busy_o          = (state_q != S_IDLE);
    assign kr_idx_o        = kr_idx_q;
    assign row_idx_o       = row_idx_q;

endmodule

// File: tb/tb_conv_wave_sequencer.sv
// Scoreboard bench for conv_wave_sequencer: expected pop masks are queued at layer start
// and matched against each pop; a small input-buffer model drives ib_ready_i.
module tb_conv_wave_sequencer;
    localparam int BW = 64;
    localparam int RW = 16;

    logic          clk_i = 1'b0;
    logic          rst_async_n_i;
    logic          start_i;
    logic [31:0]   cfg_img_w_i;
    logic [31:0]   cfg_img_h_i;
    logic [3:0]    cfg_kernel_r_i;
    logic          ib_start_o;
    logic          ib_ready_i;
    logic [BW-1:0] pop_o;
    logic          pre_wave_done_o;
    logic          sa_ready_i;
    logic          wave_valid_o;
    logic [3:0]    kr_idx_o;
    logic [RW-1:0] row_idx_o;
    logic          busy_o;
    logic          done_o;
    logic          err_cfg_o;

    conv_wave_sequencer #(.BANK_WIDTH(BW), .ROW_W(RW)) dut (
        .clk_i           (clk_i),
        .rst_async_n_i   (rst_async_n_i),
        .start_i         (start_i),
        .cfg_img_w_i     (cfg_img_w_i),
        .cfg_img_h_i     (cfg_img_h_i),
        .cfg_kernel_r_i  (cfg_kernel_r_i),
        .ib_start_o      (ib_start_o),
        .ib_ready_i      (ib_ready_i),
        .pop_o           (pop_o),
        .pre_wave_done_o (pre_wave_done_o),
        .sa_ready_i      (sa_ready_i),
        .wave_valid_o    (wave_valid_o),
        .kr_idx_o        (kr_idx_o),
        .row_idx_o       (row_idx_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_cfg_o       (err_cfg_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;
    logic [BW-1:0] exp_q[$];

    int  cyc = 0;
    int  ib_start_cnt, pwd_cnt, done_cnt, err_cnt, pop_cnt;
    int  t_pwd, min_gap;
    bit  gap_pending;
    bit  ib_auto = 1'b1;
    int  ib_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic clear_counts();
        ib_start_cnt = 0;
        pwd_cnt      = 0;
        done_cnt     = 0;
        err_cnt      = 0;
        pop_cnt      = 0;
        gap_pending  = 1'b0;
        min_gap      = 1000000;
    endtask

    // Monitor + input-buffer model
    initial begin
        forever begin
            @(negedge clk_i);
            cyc++;
            if (rst_async_n_i) begin
                if (ib_start_o) ib_start_cnt++;
                if (done_o) done_cnt++;
                if (err_cfg_o) err_cnt++;
                if (wave_valid_o && sa_ready_i && gap_pending) begin
                    if (cyc - t_pwd < min_gap) min_gap = cyc - t_pwd;
                    gap_pending = 1'b0;
                end
                if (pre_wave_done_o) begin
                    pwd_cnt++;
                    t_pwd       = cyc;
                    gap_pending = 1'b1;
                end
                if (pop_o != '0) begin
                    pop_cnt++;
                    if (exp_q.size() == 0) chk("pop_unexpected", pop_o, 64'd0);
                    else chk("pop_mask", pop_o, exp_q.pop_front());
                end
                if (ib_auto) begin
                    if (ib_start_o) begin
                        ib_ready_i = 1'b0;
                        ib_cnt     = 3;
                    end else if (pre_wave_done_o) begin
                        ib_ready_i = 1'b0;
                        ib_cnt     = 2;
                    end else if (ib_cnt > 0) begin
                        ib_cnt--;
                        if (ib_cnt == 0) ib_ready_i = 1'b1;
                    end
                end
            end
        end
    end

    task automatic start_layer(input int w, input int h, input int k);
        logic [BW-1:0] m;
        m = '0;
        for (int i = 0; i < BW; i++) if (i < w) m[i] = 1'b1;
        exp_q.delete();
        for (int r = 0; r < h - k + 1; r++) exp_q.push_back(m);
        cfg_img_w_i    = 32'(w);
        cfg_img_h_i    = 32'(h);
        cfg_kernel_r_i = 4'(k);
        clear_counts();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic finish_layer(input string tag, input int h, input int k);
        int budget;
        budget = 3000;
        while (done_cnt == 0 && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) chk({tag, "_done_timeout"}, done_cnt, 1);
        tick();
        tick();
        chk({tag, "_pops"}, pop_cnt, h - k + 1);
        chk({tag, "_pwd"}, pwd_cnt, h - k - 1);
        chk({tag, "_done"}, done_cnt, 1);
        chk({tag, "_ibstart"}, ib_start_cnt, 1);
        chk({tag, "_row_final"}, row_idx_o, h - k + 1);
        chk({tag, "_busy_end"}, busy_o, 0);
        chk({tag, "_sb_left"}, exp_q.size(), 0);
    endtask

    task automatic run_illegal(input string tag, input int w, input int h, input int k);
        cfg_img_w_i    = 32'(w);
        cfg_img_h_i    = 32'(h);
        cfg_kernel_r_i = 4'(k);
        clear_counts();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk({tag, "_busy_check"}, busy_o, 1);
        tick();
        chk({tag, "_busy_after2"}, busy_o, 0);
        tick();
        tick();
        chk({tag, "_err_once"}, err_cnt, 1);
        chk({tag, "_no_ibstart"}, ib_start_cnt, 0);
    endtask

    task automatic wait_kr(input string tag, input logic [3:0] kr);
        int budget;
        budget = 200;
        while (!(wave_valid_o && kr_idx_o == kr) && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) chk({tag, "_wait_timeout"}, kr_idx_o, kr);
    endtask

    initial begin
        rst_async_n_i  = 1'b0;
        start_i        = 1'b1;
        cfg_img_w_i    = 32'd28;
        cfg_img_h_i    = 32'd28;
        cfg_kernel_r_i = 4'd5;
        ib_ready_i     = 1'b0;
        sa_ready_i     = 1'b1;
        clear_counts();
        #1;
        chk("rst_pop", pop_o, 64'd0);
        chk("rst_outs", {ib_start_o, pre_wave_done_o, wave_valid_o, busy_o, done_o, err_cfg_o,
                         kr_idx_o, row_idx_o}, 64'd0);
        tick();
        tick();
        start_i = 1'b0;
        tick();
        rst_async_n_i = 1'b1;
        tick();
        tick();
        chk("idle_busy", busy_o, 0);
        chk("idle_no_pulse", ib_start_cnt + err_cnt + done_cnt, 0);

        // Nominal layer
        start_layer(28, 28, 5);
        finish_layer("nominal", 28, 5);

        // Illegal shapes
        run_illegal("k0", 28, 28, 0);
        run_illegal("w65", 65, 28, 5);
        run_illegal("k_gt_w", 4, 28, 5);
        run_illegal("h_eq_k", 28, 5, 5);

        // Full-bank width
        start_layer(64, 7, 5);
        finish_layer("w64", 7, 5);

        // Backpressure at kr_idx=2
        start_layer(8, 7, 5);
        wait_kr("bp", 4'd2);
        sa_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_kr_hold", kr_idx_o, 2);
            chk("bp_no_pop", pop_o, 64'd0);
            chk("bp_valid", wave_valid_o, 1);
        end
        sa_ready_i = 1'b1;
        tick();
        chk("bp_resume", kr_idx_o, 3);
        finish_layer("bp", 7, 5);

        // Refill guard with ib_ready stuck high
        ib_auto    = 1'b0;
        ib_ready_i = 1'b1;
        start_layer(16, 10, 3);
        finish_layer("guard", 10, 3);
        chk("guard_gap_ge2", (min_gap >= 2 && min_gap < 1000000), 1);
        ib_auto    = 1'b1;
        ib_ready_i = 1'b0;

        // Reset mid-layer
        start_layer(28, 28, 5);
        wait_kr("mid", 4'd1);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("mid_start_ignored", ib_start_cnt, 1);
        chk("mid_still_wave", busy_o, 1);
        wait_kr("mid2", 4'd3);
        rst_async_n_i = 1'b0;
        #1;
        chk("mid_rst_pop", pop_o, 64'd0);
        chk("mid_rst_outs", {ib_start_o, pre_wave_done_o, wave_valid_o, busy_o, done_o, err_cfg_o,
                             kr_idx_o, row_idx_o}, 64'd0);
        exp_q.delete();
        ib_cnt     = 0;
        ib_ready_i = 1'b0;
        tick();
        tick();
        rst_async_n_i = 1'b1;
        clear_counts();
        for (int i = 0; i < 6; i++) tick();
        chk("post_rst_idle", busy_o, 0);
        chk("post_rst_no_pulse", ib_start_cnt + err_cnt + done_cnt + pwd_cnt + pop_cnt, 0);
        start_layer(28, 28, 5);
        finish_layer("after_rst", 28, 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
